hht_mem_arb: RTL and testbench
==============================

// Module: hht_mem_arb
// PURPOSE
// - Shares one fixed-latency memory read port between three requesters: CPU (id 0),
//   HHT column-index fetcher (id 1, wdata_col_base stream), HHT vector gather (id 2, v_values_base).
// - Sits between the HHT control datapath and the data memory.
// - Returns each read to the requester that issued it, tagged through a latency pipe.
// - Supports a flush/drain handshake so control can quiesce the port between SpMV passes.
// PARAMETERS
// - AW         32  address width
// - DW         32  data width
// - MEM_LAT    2   cycles from accepted mem_re to mem_rdata valid (>=1)
// - STARVE_MAX 4   consecutive CPU grants allowed while an HHT requester waits
// PORTS
// - Clk         in   1        clock, all logic on rising edge
// - Rst         in   1        synchronous active-high reset
// - req         in   3        per-requester read request, held until granted
// - addr0/1/2   in   AW       requester addresses, stable while req is high
// - gnt         out  3        one-hot grant; a request completes in a cycle where req&gnt
// - rvalid      out  3        one-hot response strobe, 1 cycle
// - rdata       out  DW       response data, qualified by rvalid
// - mem_re      out  1        memory read enable
// - mem_addr    out  AW       memory address
// - mem_ready   in   1        memory accepts mem_re this cycle
// - mem_rdata   in   DW       valid exactly MEM_LAT cycles after an accepted read
// - flush       in   1        request drain, level
// - flush_done  out  1        1-cycle pulse: drained, no reads in flight
// - busy        out  1        any read in flight or any grant this cycle
// BEHAVIOUR
// - Reset values: gnt=0, rvalid=0, rdata=0, mem_re=0, mem_addr=0, flush_done=0, busy=0.
//   rr_ptr=1, starve_cnt=0, tag pipe cleared, FSM=RUN.
// - Grant logic is combinational from req, state and registers.
//   At most one gnt bit per cycle, and only when mem_ready=1 and FSM=RUN.
// - mem_re = |gnt; mem_addr = address of the granted requester (same cycle, 0 latency).
// - Priority:
//   - CPU wins unless starve_cnt==STARVE_MAX and (req[1]|req[2]).
//   - Ids 1 and 2 round-robin via rr_ptr; after granting id k in {1,2}, rr_ptr points to the other id.
// - starve_cnt:
//   - +1 on each CPU grant while req[1]|req[2].
//   - Cleared on any HHT grant, or when no HHT request is pending.
//   - Saturates at STARVE_MAX.
// - Tag pipe: MEM_LAT stages of {valid, id[1:0]}, shifted every cycle; stage 0 loads {mem_re, granted id}.
//   - At the final stage: rvalid[id]=valid, rdata=mem_rdata, registered.
//   - Total req-grant to rvalid latency = MEM_LAT+1 cycles.
//   - When the final stage is invalid, rdata holds its previous value.
// - mem_ready=0: no grant and starve_cnt unchanged; the tag pipe keeps shifting
//   (responses in flight are unaffected).
// - FSM:
//   - RUN -> DRAIN when flush=1. No grant is issued in the transition cycle.
//   - DRAIN: no grants. When the tag pipe is empty and the last rvalid has issued,
//     pulse flush_done and -> DONE.
//   - DONE -> RUN when flush=0; while flush stays 1, remain in DONE with no grants.
// - Simultaneous flush and req in RUN: flush wins, req is not granted.
// - Rst mid-operation: in-flight reads are discarded; no rvalid after Rst.
// - busy = (|gnt) | any tag-pipe valid.
// STRUCTURE
// - Shared package hht_pkg: typedef req_id_t (2b: REQ_CPU=0, REQ_COL=1, REQ_VAL=2),
//   arb_state_t {RUN, DRAIN, DONE}, typedef tag_t {logic v; req_id_t id}.
// - One sub-module, hht_tag_pipe: parameterised MEM_LAT shift register of tag_t with an empty flag.
// - Arbiter, starvation counter and FSM live in the top.
// TESTING
// - Single HHT read: req[1], addr1=180, mem returns 1 after MEM_LAT
//   -> gnt[1] cycle 0, rvalid[1]=1 and rdata=1 at cycle 3.
// - HHT contention: req[1]&req[2] held, addr 181/2
//   -> grants alternate 1,2,1,2; rvalid order matches; data 13 and 48.
// - Starvation: req[0] held, cpu_addr=126, and req[2] held
//   -> 4 CPU grants, then 1 grant to id 2, then CPU again.
// - Memory stall: mem_ready=0 for 3 cycles with req[1]
//   -> no gnt, no mem_re; grant on first ready cycle; earlier in-flight rvalid still on time.
// - Flush with 2 reads in flight
//   -> no new grants, both rvalid arrive, flush_done pulses once, and RUN resumes only after flush=0.
// - Rst asserted one cycle after a grant -> all outputs 0 next cycle, no rvalid ever appears.

Source files
------------

// File: rtl/hht_pkg.sv
// Shared types for the HHT memory arbiter.
//   req_id_t    : requester id (CPU, column-index fetcher, vector gather)
//   arb_state_t : arbiter flush FSM state
//   tag_t       : latency-pipe tag {valid, requester id}
package hht_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [ID_W-1:0] {
        REQ_CPU = 2'd0,
        REQ_COL = 2'd1,
        REQ_VAL = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } tag_t;

    // One-hot requester vector for an id.
    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        case (id)
            REQ_CPU: return 3'b001;
            REQ_COL: return 3'b010;
            REQ_VAL: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/hht_tag_pipe.sv
// MEM_LAT-deep shift register of read tags, aligned with the memory latency.
//   Clk, Rst  : clock, synchronous active-high reset (clears all tags)
//   tag_in    : tag loaded into stage 0 every cycle
//   tag_out   : final stage, valid in the cycle mem_rdata is valid
//   empty     : no valid tag in any stage
module hht_tag_pipe
    import hht_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic empty
);

    tag_t [LAT-1:0] stage_q;
    tag_t [LAT-1:0] stage_d;
    logic [LAT-1:0] valid_vec;

    // Shift by one stage, stage 0 takes the new tag.
    generate
        if (LAT == 1) begin : g_single
            assign stage_d = tag_in;
        end else begin : g_multi
            assign stage_d = {stage_q[LAT-2:0], tag_in};
        end
    endgenerate

    for (genvar g = 0; g < LAT; g++) begin : g_valid
        assign valid_vec[g] = stage_q[g].v;
    end

    assign empty   = ~|valid_vec;
    assign tag_out = stage_q[LAT-1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/hht_mem_arb.sv
// Three-way arbiter for one fixed-latency memory read port (CPU, HHT column
// fetcher, HHT vector gather) with starvation guard and flush/drain handshake.
//   Clk, Rst            : clock, synchronous active-high reset
//   req, addr0/1/2      : per-requester read request (held until granted) and address
//   gnt                 : one-hot grant, combinational
//   rvalid, rdata       : registered one-hot response strobe and data
//   mem_re, mem_addr    : memory read enable/address, same cycle as gnt
//   mem_ready, mem_rdata: memory accept and read data (MEM_LAT cycles later)
//   flush, flush_done   : drain request (level) and drained pulse
//   busy                : grant this cycle or any read in flight
module hht_mem_arb
    import hht_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [2:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    input  logic          flush,
    output logic          flush_done,
    output logic          busy
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q, state_d;
    req_id_t       rr_ptr_q, rr_ptr_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [2:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          flush_done_q, flush_done_d;

    req_id_t gnt_id;
    logic    hht_req;
    tag_t    tag_in, tag_out;
    logic    pipe_empty;

    assign hht_req = req[1] | req[2];

    // Grant selection: CPU first unless the HHT side has waited STARVE_MAX grants.
    always_comb begin
        gnt    = '0;
        gnt_id = REQ_CPU;
        if (!Rst && state_q == RUN && !flush && mem_ready) begin
            if (req[0] && !(starve_cnt_q == SC_W'(STARVE_MAX) && hht_req)) begin
                gnt_id = REQ_CPU;
                gnt    = 3'b001;
            end else if (req[1] && req[2]) begin
                gnt_id = rr_ptr_q;
                gnt    = id_onehot(rr_ptr_q);
            end else if (req[1]) begin
                gnt_id = REQ_COL;
                gnt    = 3'b010;
            end else if (req[2]) begin
                gnt_id = REQ_VAL;
                gnt    = 3'b100;
            end
        end
    end

    assign mem_re = |gnt;

    always_comb begin
        mem_addr = '0;
        if (mem_re) begin
            case (gnt_id)
                REQ_CPU: mem_addr = addr0;
                REQ_COL: mem_addr = addr1;
                REQ_VAL: mem_addr = addr2;
                default: mem_addr = '0;
            endcase
        end
    end

    // Starvation counter and HHT round-robin pointer; frozen while memory stalls.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        if (mem_ready) begin
            if (gnt[1] || gnt[2]) begin
                starve_cnt_d = '0;
            end else if (!hht_req) begin
                starve_cnt_d = '0;
            end else if (gnt[0] && starve_cnt_q != SC_W'(STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + SC_W'(1);
            end
        end
        if (gnt[1]) begin
            rr_ptr_d = REQ_VAL;
        end else if (gnt[2]) begin
            rr_ptr_d = REQ_COL;
        end
    end

    assign tag_in.v  = mem_re;
    assign tag_in.id = gnt_id;

    hht_tag_pipe #(
        .LAT (MEM_LAT)
    ) u_tag_pipe (
        .Clk     (Clk),
        .Rst     (Rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .empty   (pipe_empty)
    );

    // Response register; rdata holds when no response retires.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_out.v) begin
            rvalid_d = id_onehot(tag_out.id);
            rdata_d  = mem_rdata;
        end
    end

    // Flush FSM: drained once the pipe is empty and the last rvalid has been presented.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty && !(|rvalid_q)) begin
                    flush_done_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (!flush) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= RUN;
            rr_ptr_q     <= REQ_COL;
            starve_cnt_q <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign flush_done = flush_done_q;
    assign busy       = mem_re | ~pipe_empty;

endmodule

// File: tb/tb_hht_mem_arb.sv
module tb_hht_mem_arb;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [2:0]  req;
    logic [31:0] addr [3];
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata, mem_addr, mem_rdata;
    logic        mem_re, mem_ready, flush, flush_done, busy;

    hht_mem_arb #(
        .AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clk(Clk), .Rst(Rst), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          n_chk = 0, n_err = 0;
    int          cyc = 0;
    bit          started = 0;
    logic [2:0]  gnt_prev = '0;
    int          rate [3];
    bit          fixed_addr = 0;
    int          fd_count = 0;
    logic [31:0] last_data = '0;

    // Reference model state: arbitration bookkeeping in plain integers.
    int m_st = 0;       // 0 run, 1 draining, 2 drained
    int m_cnt = 0;
    int m_rr = 1;
    int m_last_g = -100;
    int m_fd_due = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'd180: return 32'd1;
            32'd181: return 32'd13;
            32'd2:   return 32'd48;
            default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Memory: returns data MEM_LAT cycles after an accepted read, junk otherwise.
    bit          acc_n;
    logic [31:0] acc_addr_n;
    bit          pv [MEM_LAT];
    logic [31:0] pa [MEM_LAT];
    always @(negedge Clk) begin
        acc_n      = mem_re & mem_ready;
        acc_addr_n = mem_addr;
    end
    always @(posedge Clk) begin
        #1;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = acc_n;
        pa[0] = acc_addr_n;
        mem_rdata = pv[MEM_LAT-1] ? mem_val(pa[MEM_LAT-1]) : $urandom;
    end

    // Reference model: expected grant/port/busy/flush_done, pushes expected responses.
    always @(negedge Clk) if (started) begin
        int eid;
        logic [2:0] eg;
        logic [31:0] ea;
        bit hht;
        hht = req[1] | req[2];
        eid = -1;
        if (!Rst && m_st == 0 && !flush && mem_ready) begin
            if (req[0] && !(m_cnt == STARVE_MAX && hht)) eid = 0;
            else if (req[1] && req[2]) eid = m_rr;
            else if (req[1]) eid = 1;
            else if (req[2]) eid = 2;
        end
        eg = (eid >= 0) ? (3'b001 << eid) : 3'b000;
        ea = (eid >= 0) ? addr[eid] : 32'd0;
        check("gnt", gnt, eg);
        check("mem_re", mem_re, (eid >= 0));
        check("mem_addr", mem_addr, ea);
        check("busy", busy, (eid >= 0) || (m_last_g >= cyc - MEM_LAT));
        check("flush_done", flush_done, (m_fd_due == cyc));
        if (flush_done) fd_count++;
        if (eid >= 0) sb.push_back('{id: eid, data: mem_val(ea), due: cyc + MEM_LAT + 1});
        if (Rst) begin
            m_st = 0; m_cnt = 0; m_rr = 1; m_last_g = -100; m_fd_due = -1;
        end else begin
            if (mem_ready) begin
                if (eid == 1 || eid == 2) m_cnt = 0;
                else if (!hht) m_cnt = 0;
                else if (eid == 0 && m_cnt < STARVE_MAX) m_cnt++;
            end
            if (eid == 1 || eid == 2) m_rr = 3 - eid;
            if (eid >= 0) m_last_g = cyc;
            case (m_st)
                0: if (flush) m_st = 1;
                1: if (m_last_g + MEM_LAT + 1 < cyc) begin m_st = 2; m_fd_due = cyc + 1; end
                default: if (!flush) m_st = 0;
            endcase
        end
        gnt_prev = eg;
    end

    // Monitor: pops expected responses in the cycle they must appear.
    always @(negedge Clk) if (started) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid", rvalid, 3'b001 << e.id);
            check("rdata", rdata, e.data);
            last_data = e.data;
        end else begin
            check("rvalid_idle", rvalid, 3'b000);
            check("rdata_hold", rdata, last_data);
        end
        if (Rst) begin
            sb.delete();
            last_data = '0;
        end
    end

    // Advance one cycle and update requesters: granted ones re-request per rate.
    task automatic tick();
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (gnt_prev[i]) begin
                if ($urandom_range(0, 99) < rate[i]) begin
                    req[i] = 1'b1;
                    if (!fixed_addr) addr[i] = $urandom_range(0, 1023);
                end else begin
                    req[i] = 1'b0;
                end
            end else if (!req[i] && rate[i] != 0 && $urandom_range(0, 99) < rate[i]) begin
                req[i] = 1'b1;
                if (!fixed_addr) addr[i] = $urandom_range(0, 1023);
            end
        end
    endtask

    task automatic set_rates(input int r0, input int r1, input int r2);
        rate[0] = r0; rate[1] = r1; rate[2] = r2;
    endtask

    initial begin
        int fd_base;
        Rst = 1'b1; req = '0; flush = 1'b0; mem_ready = 1'b1;
        addr[0] = '0; addr[1] = '0; addr[2] = '0;
        set_rates(0, 0, 0);
        @(posedge Clk);
        #1 started = 1;
        tick(); tick();
        Rst = 1'b0;
        @(negedge Clk);
        check("reset_rdata", rdata, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_busy", busy, 0);
        check("reset_flush_done", flush_done, 0);

        // Single HHT read of address 180.
        tick(); req[1] = 1'b1; addr[1] = 32'd180;
        repeat (6) tick();

        // HHT contention, fixed addresses 181 / 2.
        fixed_addr = 1; addr[1] = 32'd181; addr[2] = 32'd2;
        set_rates(0, 100, 100); req[1] = 1'b1; req[2] = 1'b1;
        repeat (8) tick();
        set_rates(0, 0, 0);
        repeat (6) tick();

        // Starvation: CPU at 126 against the vector gather.
        addr[0] = 32'd126; addr[2] = 32'd9;
        set_rates(100, 0, 100); req[0] = 1'b1; req[2] = 1'b1;
        repeat (12) tick();
        set_rates(0, 0, 0);
        repeat (6) tick();
        fixed_addr = 0;

        // Memory stall with a CPU read still in flight.
        req[0] = 1'b1; addr[0] = 32'd50;
        tick(); mem_ready = 1'b0; req[1] = 1'b1; addr[1] = 32'd77;
        tick(); tick(); tick();
        mem_ready = 1'b1;
        repeat (6) tick();

        // Flush with two reads in flight and a CPU request waiting.
        req[1] = 1'b1; addr[1] = 32'd300;
        tick(); req[2] = 1'b1; addr[2] = 32'd301;
        tick(); flush = 1'b1; req[0] = 1'b1; addr[0] = 32'd5;
        fd_base = fd_count;
        repeat (10) tick();
        check("flush_done_count", fd_count - fd_base, 1);
        flush = 1'b0;
        repeat (6) tick();

        // Reset one cycle after a grant: the read is discarded.
        req[1] = 1'b1; addr[1] = 32'd33;
        tick(); Rst = 1'b1; req = '0;
        tick(); Rst = 1'b0;
        repeat (6) tick();

        // Randomised traffic with stalls and flush pulses.
        for (int n = 0; n < 2000; n++) begin
            if (n % 64 == 0) set_rates($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100));
            tick();
            mem_ready = ($urandom_range(0, 99) < 80);
            if (flush) flush = ($urandom_range(0, 99) >= 20);
            else       flush = ($urandom_range(0, 99) < 2);
        end

        set_rates(0, 0, 0); flush = 1'b0; mem_ready = 1'b1;
        repeat (30) tick();
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
